// File: rtl/honzales_pkg.sv
// rtl/honzales_pkg.sv - shared encodings and constants for the honzales pixel link
package honzales_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_PIX  = 2'd1,
        ST_SEND      = 2'd2,
        ST_FRAME_END = 2'd3
    } tx_state_e;

    localparam int BYTES_PER_PIX = 3;
    localparam int R_OFF         = 16;
    localparam int G_OFF         = 8;
    localparam int B_OFF         = 0;

    // Counter width that stays at least one bit for degenerate sizes of 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/honzales_xy_counter.sv
// rtl/honzales_xy_counter.sv - raster position counter for one WIDTH x HEIGHT frame
module honzales_xy_counter
    import honzales_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    localparam int XW    = clog2_min1(WIDTH),
    localparam int YW    = clog2_min1(HEIGHT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_x_o,
    output logic          last_frame_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          last_y;

    assign last_x_o     = (x_q == XW'(WIDTH - 1));
    assign last_y       = (y_q == YW'(HEIGHT - 1));
    assign last_frame_o = last_x_o && last_y;
    assign x_o          = x_q;
    assign y_o          = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (inc_i) begin
            if (last_x_o) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/honzales_pixel_tx.sv
// rtl/honzales_pixel_tx.sv - serialises RGB pixels onto an 8-bit pad bus with toggle strobe
module honzales_pixel_tx
    import honzales_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int HEIGHT      = 64,
    parameter int HOLD_CYCLES = 4,
    parameter int OEB_W       = 10
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    input  logic [23:0]      pix_data_i,
    output logic [7:0]       io_data_o,
    output logic             io_strobe_o,
    output logic             io_sof_o,
    output logic             io_eol_o,
    output logic [OEB_W-1:0] io_oeb_o,
    output logic             frame_done_o
);

    localparam int              HW          = clog2_min1(HOLD_CYCLES);
    localparam int              XW          = clog2_min1(WIDTH);
    localparam int              YW          = clog2_min1(HEIGHT);
    localparam logic [HW-1:0]   HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [1:0]      LAST_BYTE   = 2'(BYTES_PER_PIX - 1);

    tx_state_e        state_q, state_d;
    logic [15:0]      pix_q, pix_d;
    logic [7:0]       data_q, data_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             strobe_q, strobe_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic [OEB_W-1:0] oeb_q, oeb_d;

    logic          accept, hold_zero, last_byte;
    logic          xy_inc, xy_clr, last_x, last_frame;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    assign hold_zero = (hold_cnt_q == '0);
    assign last_byte = (byte_idx_q == LAST_BYTE);
    assign accept    = pix_valid_i && pix_ready_o;

    honzales_xy_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_xy (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .inc_i        (xy_inc),
        .clr_i        (xy_clr),
        .x_o          (x),
        .y_o          (y),
        .last_x_o     (last_x),
        .last_frame_o (last_frame)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_PIX;
                ST_WAIT_PIX:  if (pix_valid_i) state_d = ST_SEND;
                ST_SEND:      if (hold_zero && last_byte)
                                  state_d = last_frame ? ST_FRAME_END : ST_WAIT_PIX;
                ST_FRAME_END: state_d = ST_WAIT_PIX;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pix_ready_o  = (state_q == ST_WAIT_PIX) && en_i;
        frame_done_o = (state_q == ST_FRAME_END);
        xy_inc       = en_i && (state_q == ST_SEND) && hold_zero && last_byte;
        xy_clr       = !en_i || (state_q == ST_FRAME_END);
    end

    // G and B wait in a 16-bit shift register; R goes straight to the pads on accept.
    always_comb begin
        pix_d      = pix_q;
        data_d     = data_q;
        hold_cnt_d = hold_cnt_q;
        byte_idx_d = byte_idx_q;
        strobe_d   = strobe_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        oeb_d      = {OEB_W{~en_i}};
        if (!en_i) begin
            data_d     = '0;
            sof_d      = 1'b0;
            eol_d      = 1'b0;
            byte_idx_d = '0;
            hold_cnt_d = '0;
        end else if (accept) begin
            pix_d      = {pix_data_i[G_OFF +: 8], pix_data_i[B_OFF +: 8]};
            data_d     = pix_data_i[R_OFF +: 8];
            strobe_d   = ~strobe_q;
            sof_d      = (x == '0) && (y == '0);
            eol_d      = last_x;
            byte_idx_d = '0;
            hold_cnt_d = HOLD_RELOAD;
        end else if (state_q == ST_SEND) begin
            if (!hold_zero) begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end else if (!last_byte) begin
                data_d     = pix_q[15:8];
                pix_d      = {pix_q[7:0], 8'h00};
                strobe_d   = ~strobe_q;
                byte_idx_d = byte_idx_q + 1'b1;
                hold_cnt_d = HOLD_RELOAD;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pix_q      <= '0;
            data_q     <= '0;
            hold_cnt_q <= '0;
            byte_idx_q <= '0;
            strobe_q   <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            oeb_q      <= '1;
        end else begin
            pix_q      <= pix_d;
            data_q     <= data_d;
            hold_cnt_q <= hold_cnt_d;
            byte_idx_q <= byte_idx_d;
            strobe_q   <= strobe_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            oeb_q      <= oeb_d;
        end
    end

    assign io_data_o   = data_q;
    assign io_strobe_o = strobe_q;
    assign io_sof_o    = sof_q;
    assign io_eol_o    = eol_q;
    assign io_oeb_o    = oeb_q;

endmodule

// File: tb/tb_honzales_pixel_tx.sv
// tb/tb_honzales_pixel_tx.sv - directed self-checking bench for honzales_pixel_tx
module tb_honzales_pixel_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Small 4x4 instance
    logic        a_en, a_valid, a_ready, a_strobe, a_sof, a_eol, a_fd;
    logic [23:0] a_pix;
    logic [7:0]  a_data;
    logic [9:0]  a_oeb;

    honzales_pixel_tx #(.WIDTH(4), .HEIGHT(4), .HOLD_CYCLES(4), .OEB_W(10)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .en_i(a_en), .pix_valid_i(a_valid),
        .pix_ready_o(a_ready), .pix_data_i(a_pix), .io_data_o(a_data),
        .io_strobe_o(a_strobe), .io_sof_o(a_sof), .io_eol_o(a_eol),
        .io_oeb_o(a_oeb), .frame_done_o(a_fd)
    );

    // Default 64x64 instance
    logic        b_en, b_valid, b_ready, b_strobe, b_sof, b_eol, b_fd;
    logic [23:0] b_pix;
    logic [7:0]  b_data;
    logic [9:0]  b_oeb;

    honzales_pixel_tx u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .en_i(b_en), .pix_valid_i(b_valid),
        .pix_ready_o(b_ready), .pix_data_i(b_pix), .io_data_o(b_data),
        .io_strobe_o(b_strobe), .io_sof_o(b_sof), .io_eol_o(b_eol),
        .io_oeb_o(b_oeb), .frame_done_o(b_fd)
    );

    logic [7:0] tab [0:11] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

    function automatic logic [23:0] mk_pix(input int i);
        return {tab[(3*i) % 12], tab[(3*i+1) % 12], tab[(3*i+2) % 12]};
    endfunction

    // Returns on the first sample after acceptance, with R on the pads.
    task automatic a_send(input logic [23:0] p, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (a_ready === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!timed_out) begin
            a_pix   = p;
            a_valid = 1'b1;
            @(negedge clk);
            a_valid = 1'b0;
        end
    endtask

    task automatic a_restart();
        a_en = 1'b0;
        repeat (2) @(negedge clk);
        a_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit to;
        @(negedge clk);
        checks++;
        if ({a_data, a_strobe, a_sof, a_eol, a_fd, a_oeb, a_ready} !== {8'h00, 4'b0000, 10'h3FF, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h",
                     {a_data, a_strobe, a_sof, a_eol, a_fd, a_oeb, a_ready}, {8'h00, 4'b0000, 10'h3FF, 1'b0});
        end
        rst  = 1'b0;
        a_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_oeb, a_ready} !== {10'h000, 1'b1}) begin
            failures++;
            $display("FAIL enable_oeb_ready: got %h expected %h", {a_oeb, a_ready}, {10'h000, 1'b1});
        end
        a_send(24'hA1B2C3, to);
        checks++;
        if (to || a_data !== 8'hA1) begin
            failures++;
            $display("FAIL reset_pre_send: got timeout=%0d data=%h expected timeout=0 data=a1", to, a_data);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_data, a_strobe, a_sof, a_eol, a_fd, a_oeb, a_ready} !== {8'h00, 4'b0000, 10'h3FF, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_send: got %h expected %h",
                     {a_data, a_strobe, a_sof, a_eol, a_fd, a_oeb, a_ready}, {8'h00, 4'b0000, 10'h3FF, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        bit   to;
        logic s0;
        s0 = a_strobe;
        a_send(24'hFF0000, to);
        checks++;
        if (to || {a_data, a_strobe, a_sof, a_eol, a_ready} !== {8'hFF, ~s0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_r: got to=%0d %h expected to=0 %h", to,
                     {a_data, a_strobe, a_sof, a_eol, a_ready}, {8'hFF, ~s0, 1'b1, 1'b0, 1'b0});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({a_data, a_strobe} !== {8'hFF, ~s0}) begin
            failures++;
            $display("FAIL single_r_hold: got %h expected %h", {a_data, a_strobe}, {8'hFF, ~s0});
        end
        @(negedge clk);
        checks++;
        if ({a_data, a_strobe} !== {8'h00, s0}) begin
            failures++;
            $display("FAIL single_g: got %h expected %h", {a_data, a_strobe}, {8'h00, s0});
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({a_data, a_strobe} !== {8'h00, ~s0}) begin
            failures++;
            $display("FAIL single_b: got %h expected %h", {a_data, a_strobe}, {8'h00, ~s0});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready_early: got %b expected 0", a_ready);
        end
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready_n13: got %b expected 1", a_ready);
        end
    endtask

    task automatic test_full_frame();
        int   tog = 0, fd = 0, fd_at = -1, t48 = -1, sent = 0, byte_errs = 0, flag_errs = 0;
        int   idx;
        logic ps, sof16;
        bit   pend;
        a_restart();
        ps      = a_strobe;
        sof16   = 1'b0;
        pend    = 1'b0;
        a_pix   = 24'h000000;
        a_valid = 1'b1;
        for (int c = 0; c < 400 && !(sent == 17 && tog == 51); c++) begin
            if (a_strobe !== ps) begin
                ps  = a_strobe;
                idx = tog / 3;
                if (a_data !== 8'(idx)) byte_errs++;
                if (tog % 3 == 0) begin
                    if (a_eol !== ((idx % 4) == 3)) flag_errs++;
                    if (idx < 16 && a_sof !== (idx == 0)) flag_errs++;
                    if (idx == 16) sof16 = a_sof;
                end
                tog++;
                if (tog == 48) t48 = c;
            end
            if (a_fd === 1'b1) begin
                fd++;
                fd_at = c;
            end
            if (pend) begin
                sent++;
                a_pix = {3{8'(sent)}};
                if (sent == 17) a_valid = 1'b0;
            end
            pend = a_ready && a_valid;
            @(negedge clk);
        end
        a_valid = 1'b0;
        checks++;
        if (tog !== 51) begin
            failures++;
            $display("FAIL frame_toggles: got %0d expected 51", tog);
        end
        checks++;
        if (byte_errs !== 0) begin
            failures++;
            $display("FAIL frame_bytes: got %0d bad bytes expected 0", byte_errs);
        end
        checks++;
        if (flag_errs !== 0) begin
            failures++;
            $display("FAIL frame_sof_eol: got %0d bad flags expected 0", flag_errs);
        end
        checks++;
        if (fd !== 1 || fd_at !== t48 + 4) begin
            failures++;
            $display("FAIL frame_done: got count=%0d at=%0d expected count=1 at=%0d", fd, fd_at, t48 + 4);
        end
        checks++;
        if (sof16 !== 1'b1) begin
            failures++;
            $display("FAIL frame_next_sof: got %b expected 1", sof16);
        end
    endtask

    task automatic test_default_frame();
        int   tog = 0, fd = 0, tog_at_fd = -1, fd_c = -1, errs = 0, sent = 0, p;
        logic ps;
        bit   pend;
        b_en = 1'b1;
        repeat (2) @(negedge clk);
        ps      = b_strobe;
        pend    = 1'b0;
        b_pix   = mk_pix(0);
        b_valid = 1'b1;
        for (int c = 0; c < 60000; c++) begin
            if (b_strobe !== ps) begin
                ps = b_strobe;
                if (b_data !== tab[tog % 12]) errs++;
                if (tog % 3 == 0) begin
                    p = (tog / 3) % 4096;
                    if (b_sof !== (p == 0)) errs++;
                    if (b_eol !== ((p % 64) == 63)) errs++;
                end
                tog++;
            end
            if (b_fd === 1'b1) begin
                fd++;
                tog_at_fd = tog;
                if (fd_c < 0) fd_c = c;
            end
            if (pend) begin
                sent++;
                b_pix = mk_pix(sent);
            end
            pend = b_ready && b_valid;
            if (fd_c >= 0 && c >= fd_c + 30) break;
            @(negedge clk);
        end
        b_valid = 1'b0;
        checks++;
        if (fd !== 1) begin
            failures++;
            $display("FAIL big_frame_done_count: got %0d expected 1", fd);
        end
        checks++;
        if (tog_at_fd !== 12288) begin
            failures++;
            $display("FAIL big_bytes_at_done: got %0d expected 12288", tog_at_fd);
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL big_byte_stream: got %0d errors expected 0", errs);
        end
    endtask

    task automatic test_abort();
        bit   to, to_any = 1'b0;
        logic s;
        int   bad = 0;
        a_restart();
        for (int i = 0; i < 6; i++) begin
            a_send({3{8'(i)}}, to);
            to_any |= to;
        end
        a_send(24'h112233, to);
        to_any |= to;
        checks++;
        if (to_any || {a_data, a_sof, a_eol} !== {8'h11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_r: got to=%0d %h expected to=0 %h", to_any, {a_data, a_sof, a_eol}, {8'h11, 2'b00});
        end
        repeat (4) @(negedge clk);
        checks++;
        if (a_data !== 8'h22) begin
            failures++;
            $display("FAIL abort_g: got %h expected 22", a_data);
        end
        s    = a_strobe;
        a_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_data, a_sof, a_eol, a_strobe, a_oeb, a_ready} !== {8'h00, 1'b0, 1'b0, s, 10'h3FF, 1'b0}) begin
            failures++;
            $display("FAIL abort_outputs: got %h expected %h",
                     {a_data, a_sof, a_eol, a_strobe, a_oeb, a_ready}, {8'h00, 2'b00, s, 10'h3FF, 1'b0});
        end
        for (int i = 0; i < 20; i++) begin
            if (a_fd !== 1'b0 || a_strobe !== s) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d events expected 0", bad);
        end
        a_en = 1'b1;
        @(negedge clk);
        a_send(24'h0C0C0C, to);
        checks++;
        if (to || {a_data, a_sof, a_strobe} !== {8'h0C, 1'b1, ~s}) begin
            failures++;
            $display("FAIL abort_restart_sof: got to=%0d %h expected to=0 %h", to,
                     {a_data, a_sof, a_strobe}, {8'h0C, 1'b1, ~s});
        end
    endtask

    task automatic test_valid_gaps();
        bit         to, found = 1'b0;
        logic [7:0] d0;
        logic       s0;
        int         bad = 0;
        a_restart();
        a_send(24'h123456, to);
        for (int i = 0; i < 40; i++) begin
            if (a_ready === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        d0 = a_data;
        s0 = a_strobe;
        checks++;
        if (to || !found || d0 !== 8'h56) begin
            failures++;
            $display("FAIL gap_first_pixel: got to=%0d ready=%0d data=%h expected 0 1 56", to, found, d0);
        end
        for (int i = 0; i < 7; i++) begin
            if (a_data !== d0 || a_strobe !== s0 || a_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL gap_stable: got %0d changes expected 0", bad);
        end
        a_send(24'hABCDEF, to);
        checks++;
        if (to || {a_data, a_strobe} !== {8'hAB, ~s0}) begin
            failures++;
            $display("FAIL gap_next_pixel: got to=%0d %h expected to=0 %h", to, {a_data, a_strobe}, {8'hAB, ~s0});
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        a_en    = 1'b0;
        a_valid = 1'b0;
        a_pix   = '0;
        b_en    = 1'b0;
        b_valid = 1'b0;
        b_pix   = '0;
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_abort();
        test_valid_gaps();
        test_default_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
